multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
Multi-cycle successor to the single-cycle RV32I control decoder. A Moore FSM sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives datapath enables for a shared-memory, single-ALU datapath. Adds memory-ready stalls, a parametrised wait-timeout and illegal-opcode trapping.

Parameters:
OPCODE_W, 7, opcode field width
ALUOP_W, 2, ALUOp width to ALU decoder
MEM_TIMEOUT, 16, max mem_ready wait cycles before trap; 0 disables timeout
TO_CNT_W, 5, timeout counter width; must satisfy 2^TO_CNT_W > MEM_TIMEOUT

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  reset; asynchronous, active-low
opcode  in  OPCODE_W  instruction[6:0] from IR, valid in DECODE
mem_ready  in  1  memory completes the current access this cycle
pc_write  out  1  unconditional PC update (PC+4)
pc_write_cond  out  1  PC update if ALU zero (branch)
i_or_d  out  1  0 = memory address is PC, 1 = ALUOut
ir_write  out  1  load IR
mem_read  out  1  memory read request
mem_write  out  1  memory write request
mem_to_reg  out  1  1 = writeback from MDR, 0 = from ALUOut
reg_write  out  1  register file write enable
alu_src_a  out  1  0 = PC, 1 = rs1
alu_src_b  out  2  00 = rs2, 01 = const 4, 10 = immediate
alu_op  out  ALUOP_W  00 add, 01 sub/compare, 10 funct-decoded
instr_done  out  1  one-cycle pulse on the last cycle of each instruction
trap  out  1  sticky error flag
trap_cause  out  2  01 illegal opcode, 10 memory timeout

Behaviour:
- Reset (async on reset_n low): state=FETCH, opcode_q=0, timeout count=0; every output 0 except i_or_d=0, alu_src_b=00, trap_cause=00. FETCH request outputs assert the first cycle after reset_n deasserts.
- Outputs are Moore: combinational from state and latched opcode_q only; no combinational path from opcode or mem_ready to any output except pc_write/ir_write/instr_done/reg_write qualified by mem_ready as listed.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00. Hold while mem_ready=0. With mem_ready=1: ir_write=1, pc_write=1, next DECODE.
- DECODE: latch opcode into opcode_q; alu_src_a=0, alu_src_b=10, alu_op=00 (branch target). Legal opcodes 0110011 R, 0010011 ADDI, 0000011 LW, 0100011 SW, 1100011 BEQ -> EXEC; else -> TRAP, trap_cause=01.
- EXEC: R: a=1, b=00, op=10 -> WB. ADDI: a=1, b=10, op=00 -> WB. LW/SW: a=1, b=10, op=00 -> MEM. BEQ: a=1, b=00, op=01, pc_write_cond=1, instr_done=1 -> FETCH.
- MEM: i_or_d=1; LW mem_read=1, SW mem_write=1. Hold while mem_ready=0. On mem_ready: LW -> WB; SW instr_done=1 -> FETCH.
- WB: reg_write=1, mem_to_reg=1 for LW else 0, instr_done=1 -> FETCH.
- Latency with mem_ready always 1: BEQ 3, R/ADDI/SW 4, LW 5 cycles. Each cycle of mem_ready=0 adds one.
- Timeout: counter clears on entering FETCH/MEM and on mem_ready=1; increments each waiting cycle. When MEM_TIMEOUT!=0 and count reaches MEM_TIMEOUT with mem_ready still 0 -> TRAP, trap_cause=10; mem_ready in that same cycle wins (no trap).
- TRAP: all enables 0, trap=1; sticky until reset_n low. mem_ready ignored.
- Reset mid-instruction aborts immediately; no partial write enable survives reset.

Optional Feature:
Macro MCU_JUMP_EN. Defined: JAL (1101111) and JALR (1100111) legal. EXEC computes target (JAL a=0,b=10; JALR a=1,b=10; op=00) with pc_write=1, then WB writes link (PC+4 held in ALUOut path, mem_to_reg=0), 4 cycles. Undefined: both opcodes trap with cause 01.

Decomposition:
Package mcu_pkg: opcode constants (OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_JAL, OP_JALR), state enum typedef, ALUOp and alu_src_b encodings, trap cause codes. One sub-module natural: mcu_timeout_ctr (parametrised wait counter, clear/inc/expired).

Test Plan:
- Reset then ADD (0110011), mem_ready=1 -> states FETCH,DECODE,EXEC,WB; reg_write=1 in cycle 4, alu_op=10, instr_done pulse cycle 4.
- LW (0000011), mem_ready low 3 cycles in MEM -> 8 cycles total; mem_read,i_or_d=1 held in MEM; WB mem_to_reg=1.
- BEQ (1100011) -> 3 cycles, pc_write_cond=1 and alu_op=01 only in EXEC, reg_write never asserted.
- Opcode 1111111 -> TRAP after DECODE, trap=1, trap_cause=01, all enables 0 for 10+ cycles until reset_n low.
- MEM_TIMEOUT=16, mem_ready=0 in FETCH -> trap_cause=10 after 16 wait cycles; repeat with mem_ready=1 on cycle 16 -> no trap, DECODE.
- reset_n low during SW MEM -> mem_write drops asynchronously, state FETCH after release.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared definitions for the multicycle RV32I control unit.
//   - opcode constants for the supported instruction classes
//   - FSM state encoding
//   - ALUOp, ALU operand-B select and trap cause encodings
//   - is_legal(): opcode legality check used in DECODE
// Optional feature macro: MCU_JUMP_EN (adds JAL/JALR to the legal set).
package mcu_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ: is_legal = 1'b1;
`ifdef MCU_JUMP_EN
      OP_JAL, OP_JALR:                     is_legal = 1'b1;
`endif
      default:                             is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mcu_timeout_ctr.sv
// Memory-wait timeout counter.
//   clk, reset_n : clock, async active-low reset
//   clr          : zero the count (not waiting on memory)
//   inc          : one more cycle spent waiting on memory
//   expired      : this waiting cycle is the LIMIT-th in a row
// LIMIT = 0 disables the timeout entirely (expired is tied low).
module mcu_timeout_ctr #(
  parameter int LIMIT = 16,
  parameter int CNT_W = 5
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (LIMIT != 0)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  generate
    if (LIMIT == 0) begin : g_no_timeout
      assign expired = 1'b0;
    end else begin : g_timeout
      // Flag on the waiting cycle that brings the count up to LIMIT, so the
      // FSM leaves on the same edge the count would reach it; a mem_ready in
      // that cycle means inc is low and no trap is taken.
      localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);
      assign expired = inc && (cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control unit: Moore FSM FETCH/DECODE/EXEC/MEM/WB driving
// the enables of a shared-memory, single-ALU datapath, with memory-ready
// stalls, a wait timeout and illegal-opcode trapping into a sticky TRAP state.
// Ports:
//   clk, reset_n     : clock, async active-low reset
//   opcode           : IR[6:0], sampled in DECODE
//   mem_ready        : memory completes the current access this cycle
//   pc_write, pc_write_cond, i_or_d, ir_write, mem_read, mem_write,
//   mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op : datapath controls
//   instr_done       : pulse on the last cycle of each instruction
//   trap, trap_cause : sticky error flag and cause (01 illegal, 10 timeout)
// Optional feature macro: MCU_JUMP_EN (JAL/JALR support).
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int OPCODE_W    = 7,
  parameter int ALUOP_W     = 2,
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_CNT_W    = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                i_or_d,
  output logic                ir_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                instr_done,
  output logic                trap,
  output logic [1:0]          trap_cause
);

  state_t              state;
  logic [OPCODE_W-1:0] opcode_q;
  logic [1:0]          aop;
  logic                waiting;
  logic                to_expired;

  assign waiting = ((state == S_FETCH) || (state == S_MEM)) && !mem_ready;

  mcu_timeout_ctr #(
    .LIMIT (MEM_TIMEOUT),
    .CNT_W (TO_CNT_W)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (!waiting),
    .inc     (waiting),
    .expired (to_expired)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_FETCH;
      opcode_q   <= '0;
      trap_cause <= CAUSE_NONE;
    end else begin
      case (state)
        S_FETCH: begin
          if (mem_ready) begin
            state <= S_DECODE;
          end else if (to_expired) begin
            state      <= S_TRAP;
            trap_cause <= CAUSE_TIMEOUT;
          end
        end
        S_DECODE: begin
          opcode_q <= opcode;
          if (is_legal(opcode)) begin
            state <= S_EXEC;
          end else begin
            state      <= S_TRAP;
            trap_cause <= CAUSE_ILLEGAL;
          end
        end
        S_EXEC: begin
          case (opcode_q)
            OP_LW, OP_SW: state <= S_MEM;
            OP_BEQ:       state <= S_FETCH;
            default:      state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            state <= (opcode_q == OP_LW) ? S_WB : S_FETCH;
          end else if (to_expired) begin
            state      <= S_TRAP;
            trap_cause <= CAUSE_TIMEOUT;
          end
        end
        S_WB:    state <= S_FETCH;
        S_TRAP:  state <= S_TRAP;
        default: state <= S_FETCH;
      endcase
    end
  end

  // Outputs are decoded from state/opcode_q and forced low while reset_n is
  // asserted: the reset state is FETCH, but no request may be visible until
  // reset releases, and an in-flight write enable must drop immediately.
  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RS2;
    aop           = ALU_ADD;
    instr_done    = 1'b0;
    trap          = 1'b0;
    if (reset_n) begin
      case (state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          // Precompute the branch target into ALUOut.
          alu_src_b = SRCB_IMM;
        end
        S_EXEC: begin
          case (opcode_q)
            OP_R: begin
              alu_src_a = 1'b1;
              aop       = ALU_FUNCT;
            end
            OP_BEQ: begin
              alu_src_a     = 1'b1;
              aop           = ALU_SUB;
              pc_write_cond = 1'b1;
              instr_done    = 1'b1;
            end
`ifdef MCU_JUMP_EN
            OP_JAL: begin
              alu_src_b = SRCB_IMM;
              pc_write  = 1'b1;
            end
            OP_JALR: begin
              alu_src_a = 1'b1;
              alu_src_b = SRCB_IMM;
              pc_write  = 1'b1;
            end
`endif
            default: begin
              // ADDI and load/store address generation.
              alu_src_a = 1'b1;
              alu_src_b = SRCB_IMM;
            end
          endcase
        end
        S_MEM: begin
          i_or_d = 1'b1;
          if (opcode_q == OP_LW) begin
            mem_read = 1'b1;
          end else begin
            mem_write  = 1'b1;
            instr_done = mem_ready;
          end
        end
        S_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (opcode_q == OP_LW);
          instr_done = 1'b1;
        end
        S_TRAP:  trap = 1'b1;
        default: ;
      endcase
    end
  end

  assign alu_op = ALUOP_W'(aop);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed testbench for multicycle_control_unit: walks ADD, LW with stalls,
// BEQ, SW, ADDI, illegal-opcode trap, fetch/mem timeouts and async reset,
// comparing state and the full control vector against hand-built values.
module tb_multicycle_control_unit;
  import mcu_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [6:0] opcode = '0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, i_or_d, ir_write, mem_read, mem_write;
  logic       mem_to_reg, reg_write, alu_src_a, instr_done, trap;
  logic [1:0] alu_src_b, alu_op, trap_cause;

  int n_checks = 0;
  int n_errors = 0;

  multicycle_control_unit #(
    .OPCODE_W(7), .ALUOP_W(2), .MEM_TIMEOUT(16), .TO_CNT_W(5)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .ir_write      (ir_write),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .instr_done    (instr_done),
    .trap          (trap),
    .trap_cause    (trap_cause)
  );

  always #5 clk = ~clk;

  logic [16:0] obs;
  assign obs = {pc_write, pc_write_cond, i_or_d, ir_write, mem_read, mem_write,
                mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                instr_done, trap, trap_cause};

  // Order: pcw pcc iod irw mr mw m2r rw a b op done trap cause
  function automatic logic [16:0] ctl(
    input logic pcw, pcc, iod, irw, mr, mw, m2r, rw, a,
    input logic [1:0] b, op,
    input logic done, tr,
    input logic [1:0] cause);
    return {pcw, pcc, iod, irw, mr, mw, m2r, rw, a, b, op, done, tr, cause};
  endfunction

  logic [16:0] c_zero, c_f_rdy, c_f_wait, c_dec, c_e_r, c_e_imm, c_e_beq;
  logic [16:0] c_m_lw, c_m_sw_wait, c_m_sw_rdy, c_wb, c_wb_lw;
  logic [16:0] c_trap_ill, c_trap_to, c_e_jal;

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_checks++;
    assert (o === e) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // Drive mem_ready for one cycle, compare mid-cycle, end just after the edge.
  task automatic cyc(input string tag, input logic mr, input state_t st,
                     input logic [16:0] c);
    mem_ready = mr;
    @(negedge clk);
    check({tag, ".state"}, 32'(dut.state), 32'(st));
    check({tag, ".ctl"}, 32'(obs), 32'(c));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    reset_n   = 1'b0;
    mem_ready = 1'b0;
    #2;
    check({tag, ".state"}, 32'(dut.state), 32'(S_FETCH));
    check({tag, ".ctl"}, 32'(obs), 32'(c_zero));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    c_zero      = '0;
    c_f_rdy     = ctl(1,0,0,1,1,0,0,0,0,2'b01,2'b00,0,0,2'b00);
    c_f_wait    = ctl(0,0,0,0,1,0,0,0,0,2'b01,2'b00,0,0,2'b00);
    c_dec       = ctl(0,0,0,0,0,0,0,0,0,2'b10,2'b00,0,0,2'b00);
    c_e_r       = ctl(0,0,0,0,0,0,0,0,1,2'b00,2'b10,0,0,2'b00);
    c_e_imm     = ctl(0,0,0,0,0,0,0,0,1,2'b10,2'b00,0,0,2'b00);
    c_e_beq     = ctl(0,1,0,0,0,0,0,0,1,2'b00,2'b01,1,0,2'b00);
    c_m_lw      = ctl(0,0,1,0,1,0,0,0,0,2'b00,2'b00,0,0,2'b00);
    c_m_sw_wait = ctl(0,0,1,0,0,1,0,0,0,2'b00,2'b00,0,0,2'b00);
    c_m_sw_rdy  = ctl(0,0,1,0,0,1,0,0,0,2'b00,2'b00,1,0,2'b00);
    c_wb        = ctl(0,0,0,0,0,0,0,1,0,2'b00,2'b00,1,0,2'b00);
    c_wb_lw     = ctl(0,0,0,0,0,0,1,1,0,2'b00,2'b00,1,0,2'b00);
    c_trap_ill  = ctl(0,0,0,0,0,0,0,0,0,2'b00,2'b00,0,1,2'b01);
    c_trap_to   = ctl(0,0,0,0,0,0,0,0,0,2'b00,2'b00,0,1,2'b10);
    c_e_jal     = ctl(1,0,0,0,0,0,0,0,0,2'b10,2'b00,0,0,2'b00);

    #1 reset_n = 1'b0;
    @(posedge clk);
    #1;
    do_reset("reset");

    // ADD: 4 cycles
    opcode = OP_R;
    cyc("add.fetch", 1'b1, S_FETCH,  c_f_rdy);
    cyc("add.dec",   1'b1, S_DECODE, c_dec);
    cyc("add.exec",  1'b1, S_EXEC,   c_e_r);
    cyc("add.wb",    1'b1, S_WB,     c_wb);

    // LW with 3 stall cycles in MEM: 8 cycles
    opcode = OP_LW;
    cyc("lw.fetch", 1'b1, S_FETCH,  c_f_rdy);
    cyc("lw.dec",   1'b1, S_DECODE, c_dec);
    cyc("lw.exec",  1'b1, S_EXEC,   c_e_imm);
    for (int i = 0; i < 3; i++) cyc("lw.mem_wait", 1'b0, S_MEM, c_m_lw);
    cyc("lw.mem",   1'b1, S_MEM,    c_m_lw);
    cyc("lw.wb",    1'b1, S_WB,     c_wb_lw);

    // BEQ: 3 cycles, back to FETCH
    opcode = OP_BEQ;
    cyc("beq.fetch", 1'b1, S_FETCH,  c_f_rdy);
    cyc("beq.dec",   1'b1, S_DECODE, c_dec);
    cyc("beq.exec",  1'b1, S_EXEC,   c_e_beq);

    // SW: 4 cycles
    opcode = OP_SW;
    cyc("sw.fetch", 1'b1, S_FETCH,  c_f_rdy);
    cyc("sw.dec",   1'b1, S_DECODE, c_dec);
    cyc("sw.exec",  1'b1, S_EXEC,   c_e_imm);
    cyc("sw.mem",   1'b1, S_MEM,    c_m_sw_rdy);

    // JAL: legal only with the jump feature
    opcode = OP_JAL;
    cyc("jal.fetch", 1'b1, S_FETCH,  c_f_rdy);
    cyc("jal.dec",   1'b1, S_DECODE, c_dec);
`ifdef MCU_JUMP_EN
    cyc("jal.exec",  1'b1, S_EXEC,   c_e_jal);
    cyc("jal.wb",    1'b1, S_WB,     c_wb);
`else
    cyc("jal.trap",  1'b1, S_TRAP,   c_trap_ill);
    do_reset("jal.reset");
`endif

    // Illegal opcode: sticky trap regardless of mem_ready
    opcode = 7'b1111111;
    cyc("ill.fetch", 1'b1, S_FETCH,  c_f_rdy);
    cyc("ill.dec",   1'b1, S_DECODE, c_dec);
    for (int i = 0; i < 12; i++) cyc("ill.trap", i[0], S_TRAP, c_trap_ill);
    do_reset("ill.reset");

    // Fetch timeout: 16 waiting cycles then TRAP
    opcode = OP_ADDI;
    for (int i = 0; i < 16; i++) cyc("tof.wait", 1'b0, S_FETCH, c_f_wait);
    cyc("tof.trap", 1'b0, S_TRAP, c_trap_to);
    do_reset("tof.reset");

    // mem_ready on the 16th cycle wins: no trap, ADDI completes
    for (int i = 0; i < 15; i++) cyc("tob.wait", 1'b0, S_FETCH, c_f_wait);
    cyc("tob.fetch", 1'b1, S_FETCH,  c_f_rdy);
    cyc("tob.dec",   1'b1, S_DECODE, c_dec);
    cyc("tob.exec",  1'b1, S_EXEC,   c_e_imm);
    cyc("tob.wb",    1'b1, S_WB,     c_wb);

    // MEM timeout on a load
    opcode = OP_LW;
    cyc("tom.fetch", 1'b1, S_FETCH,  c_f_rdy);
    cyc("tom.dec",   1'b1, S_DECODE, c_dec);
    cyc("tom.exec",  1'b1, S_EXEC,   c_e_imm);
    for (int i = 0; i < 16; i++) cyc("tom.wait", 1'b0, S_MEM, c_m_lw);
    cyc("tom.trap", 1'b0, S_TRAP, c_trap_to);
    do_reset("tom.reset");

    // Reset during a stalled SW in MEM drops mem_write immediately
    opcode = OP_SW;
    cyc("swr.fetch", 1'b1, S_FETCH,  c_f_rdy);
    cyc("swr.dec",   1'b1, S_DECODE, c_dec);
    cyc("swr.exec",  1'b1, S_EXEC,   c_e_imm);
    cyc("swr.wait",  1'b0, S_MEM,    c_m_sw_wait);
    check("swr.mem_write_before", 32'(mem_write), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("swr.mem_write_async", 32'(mem_write), 32'd0);
    check("swr.state", 32'(dut.state), 32'(S_FETCH));
    check("swr.ctl", 32'(obs), 32'(c_zero));
    @(posedge clk);
    #1 reset_n = 1'b1;
    opcode = OP_BEQ;
    cyc("swr.post_fetch", 1'b1, S_FETCH,  c_f_rdy);
    cyc("swr.post_dec",   1'b1, S_DECODE, c_dec);
    cyc("swr.post_exec",  1'b1, S_EXEC,   c_e_beq);
    cyc("swr.post_next",  1'b0, S_FETCH,  c_f_wait);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
